// File: rtl/fifo_burst_drain_if.sv
// Bus bundle between the burst drainer, its show-ahead source FIFO and the memory writer.
// slave = drainer side, master = FIFO/writer/control side.
interface fifo_burst_drain_if #(
    parameter int ADDR_W = 22
);
    logic              en;
    logic              frame_start;
    logic [9:0]        fifo_usedw;
    logic              fifo_empty;
    logic [15:0]       fifo_q;
    logic              fifo_rd_en;
    logic              wr_req;
    logic              wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic              frame_done;
    logic              underflow_err;

    modport slave (
        input  en, frame_start, fifo_usedw, fifo_empty, fifo_q, wr_ack, wr_data_ready,
        output fifo_rd_en, wr_req, wr_addr, wr_data, wr_data_valid, frame_done, underflow_err
    );

    modport master (
        output en, frame_start, fifo_usedw, fifo_empty, fifo_q, wr_ack, wr_data_ready,
        input  fifo_rd_en, wr_req, wr_addr, wr_data, wr_data_valid, frame_done, underflow_err
    );
endinterface

// File: rtl/fifo_burst_drain.sv
// Drains a show-ahead FIFO in BURST_LEN-word bursts to a memory writer, walking a frame address.
// Define FRAME_WRAP_EN to wrap to address 0 at frame end instead of stopping until frame_start.
module fifo_burst_drain #(
    parameter int BURST_LEN   = 256,
    parameter int ADDR_W      = 22,
    parameter int FRAME_WORDS = 307200
) (
    input  logic               clk,
    input  logic               reset,
    fifo_burst_drain_if.slave  bus
);
    localparam int                CNT_W     = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_q, stop_d;
    logic              pend_q, pend_d;
    logic              uflow_q, uflow_d;

    logic [ADDR_W-1:0] addr_inc;
    logic              frame_end;
    logic              vld;
    logic              rd;
    logic              can_start;

    assign addr_inc  = addr_q + STEP;
    assign frame_end = (addr_inc == FRAME_END);
    assign vld       = (state_q == DATA) && !bus.fifo_empty;
    assign rd        = vld && bus.wr_data_ready;
    assign can_start = bus.en && !stop_q && (32'(bus.fifo_usedw) >= BURST_LEN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            pend_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            pend_q  <= pend_d;
            uflow_q <= uflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        pend_d  = pend_q;
        uflow_d = uflow_q;

        if (bus.frame_start) begin
            stop_d  = 1'b0;
            uflow_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.frame_start) addr_d = '0;
                if (can_start)       state_d = REQ;
            end
            REQ: begin
                if (bus.frame_start) pend_d = 1'b1;
                if (bus.wr_ack)      state_d = DATA;
            end
            DATA: begin
                if (bus.frame_start) pend_d = 1'b1;
                // An empty head stalls the burst; the flag stays until the next frame_start.
                if (bus.fifo_empty)  uflow_d = 1'b1;
                if (rd) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                pend_d  = 1'b0;
                addr_d  = addr_inc;
                if (frame_end) begin
`ifdef FRAME_WRAP_EN
                    addr_d = '0;
`else
                    stop_d = 1'b1;
`endif
                end
                // A restart requested now or during the burst beats the increment.
                if (bus.frame_start || pend_q) begin
                    addr_d = '0;
                    stop_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.wr_req        = (state_q == REQ);
    assign bus.wr_addr       = addr_q;
    assign bus.wr_data       = (state_q == DATA) ? bus.fifo_q : 16'h0;
    assign bus.wr_data_valid = vld;
    assign bus.fifo_rd_en    = rd;
    assign bus.frame_done    = (state_q == DONE) && frame_end;
    assign bus.underflow_err = uflow_q;
endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a queue-based FIFO and writer model drive directed bursts with
// random data/ready/ack timing; popped words and burst addresses are checked against the model.
module tb_fifo_burst_drain;
    localparam int BL = 256;
    localparam int AW = 22;
    localparam int FW = 512;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_burst_drain_if #(.ADDR_W(AW)) ifc();

    fifo_burst_drain #(.BURST_LEN(BL), .ADDR_W(AW), .FRAME_WORDS(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc_n = 0;
    int pops, first_pop, last_pop, data_err, proto_err, fd_cnt, fd_cyc, gcyc;
    int req_run = 0, ack_delay = 3, rdy_mode = 0;
    logic force_empty = 1'b0, ack_force = 1'b0;
    logic [15:0] fq[$];
    logic [15:0] exp_q[$];
    int gaddr[$];
    int glen[$];

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive();
        ifc.fifo_usedw    = 10'((fq.size() > 1023) ? 1023 : fq.size());
        ifc.fifo_empty    = (fq.size() == 0) || force_empty;
        ifc.fifo_q        = (fq.size() != 0) ? fq[0] : 16'h0;
        ifc.wr_data_ready = (rdy_mode == 0) ? 1'b1 :
                            (rdy_mode == 1) ? cyc_n[0] : 1'($urandom_range(0, 1));
        ifc.wr_ack        = ack_force || (ifc.wr_req && (req_run == ack_delay));
    endtask

    task automatic clr();
        pops = 0; first_pop = -1; last_pop = -1; data_err = 0; proto_err = 0;
        fd_cnt = 0; fd_cyc = -1; gcyc = -1;
        gaddr.delete(); glen.delete();
    endtask

    task automatic push(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = seq ? 16'(i) : 16'($urandom);
            fq.push_back(w);
            exp_q.push_back(w);
        end
        drive();
    endtask

    // One clock: observe mid-cycle, then update the FIFO model and inputs just after the edge.
    task automatic cyc();
        bit pop;
        pop = 1'b0;
        @(negedge clk);
        if (reset) begin
            if (ifc.wr_req) req_run++; else req_run = 0;
            if (ifc.wr_req && ifc.wr_ack) begin
                gaddr.push_back(int'(ifc.wr_addr));
                glen.push_back(req_run);
                gcyc = cyc_n;
            end
            if (ifc.fifo_rd_en !== (ifc.wr_data_valid & ifc.wr_data_ready)) proto_err++;
            if (ifc.wr_data_valid && ifc.fifo_empty) proto_err++;
            if (ifc.fifo_rd_en) begin
                pop = 1'b1;
                if (exp_q.size() == 0 || ifc.wr_data !== exp_q[0]) data_err++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pops++;
                last_pop = cyc_n;
                if (first_pop < 0) first_pop = cyc_n;
            end
            if (ifc.frame_done) begin
                fd_cnt++;
                fd_cyc = cyc_n;
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (pop && fq.size() != 0) void'(fq.pop_front());
        drive();
    endtask

    task automatic wait_pops(input int n, input string tag);
        int k;
        k = 0;
        while (pops < n && k < 3000) begin
            cyc();
            k++;
        end
        chk({tag, " pops"}, pops, n);
    endtask

    task automatic burst_done(input string tag, input int exp_addr, input int exp_len);
        wait_pops(BL, tag);
        repeat (3) cyc();
        chk({tag, " grants"}, gaddr.size(), 1);
        chk({tag, " addr"}, (gaddr.size() != 0) ? gaddr[0] : -1, exp_addr);
        if (exp_len >= 0) chk({tag, " req_len"}, (glen.size() != 0) ? glen[0] : -1, exp_len);
        chk({tag, " data_err"}, data_err, 0);
        chk({tag, " proto_err"}, proto_err, 0);
    endtask

    initial begin
        ifc.en = 1'b0;
        ifc.frame_start = 1'b0;
        clr();
        drive();
        #12;
        chk("rst wr_req", int'(ifc.wr_req), 0);
        chk("rst wr_data_valid", int'(ifc.wr_data_valid), 0);
        chk("rst fifo_rd_en", int'(ifc.fifo_rd_en), 0);
        chk("rst frame_done", int'(ifc.frame_done), 0);
        chk("rst wr_data", int'(ifc.wr_data), 0);
        chk("rst underflow_err", int'(ifc.underflow_err), 0);
        chk("rst wr_addr", int'(ifc.wr_addr), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // en=0 blocks starting even with a full burst waiting; stray acks are ignored
        push(BL, 1'b1);
        ack_force = 1'b1;
        drive();
        repeat (3) cyc();
        ack_force = 1'b0;
        drive();
        repeat (7) cyc();
        chk("en0 grants", gaddr.size(), 0);
        chk("en0 wr_req", int'(ifc.wr_req), 0);
        chk("en0 wr_data_valid", int'(ifc.wr_data_valid), 0);

        // burst 0: ack on the 4th request cycle, ready held high, data 0..255
        ifc.en = 1'b1;
        ack_delay = 3;
        rdy_mode = 0;
        clr();
        drive();
        burst_done("b0", 0, 4);
        chk("b0 first pop latency", first_pop - gcyc, 1);
        chk("b0 pop span", last_pop - first_pop, BL - 1);
        chk("b0 frame_done", fd_cnt, 0);

        // burst 1: ready toggling, ends the frame
        ack_delay = int'($urandom_range(0, 4));
        rdy_mode = 1;
        clr();
        push(BL, 1'b0);
        burst_done("b1", BL, ack_delay + 1);
        chk("b1 pop span", last_pop - first_pop, 2 * (BL - 1));
        chk("b1 frame_done count", fd_cnt, 1);
        chk("b1 frame_done timing", fd_cyc - last_pop, 1);

        // burst 2: wrap continues at 0; otherwise blocked until frame_start
        rdy_mode = 2;
        ack_delay = int'($urandom_range(0, 4));
        clr();
        push(BL, 1'b0);
`ifndef FRAME_WRAP_EN
        repeat (40) cyc();
        chk("stop grants", gaddr.size(), 0);
        chk("stop wr_req", int'(ifc.wr_req), 0);
        ifc.frame_start = 1'b1;
        cyc();
        ifc.frame_start = 1'b0;
`endif
        burst_done("b2", 0, -1);

        // burst 3: 5-cycle empty gap mid-burst, then frame_start while in DATA
        rdy_mode = 0;
        clr();
        push(BL, 1'b0);
        wait_pops(100, "b3 pre");
        force_empty = 1'b1;
        drive();
        repeat (5) cyc();
        chk("b3 no pops while empty", pops, 100);
        chk("b3 underflow set", int'(ifc.underflow_err), 1);
        force_empty = 1'b0;
        drive();
        repeat (3) cyc();
        chk("b3 underflow sticky", int'(ifc.underflow_err), 1);
        ifc.frame_start = 1'b1;
        cyc();
        ifc.frame_start = 1'b0;
        chk("b3 underflow cleared", int'(ifc.underflow_err), 0);
        burst_done("b3", BL, -1);

        // burst 4: the pending frame_start restarted the address
        rdy_mode = 2;
        ack_delay = int'($urandom_range(0, 4));
        clr();
        push(BL, 1'b0);
        burst_done("b4", 0, -1);

        // burst 5: reset in the middle of DATA
        rdy_mode = 0;
        clr();
        push(BL, 1'b0);
        wait_pops(50, "b5 pre");
        chk("b5 addr", (gaddr.size() != 0) ? gaddr[0] : -1, BL);
        reset = 1'b0;
        #1;
        chk("b5 rst wr_req", int'(ifc.wr_req), 0);
        chk("b5 rst wr_data_valid", int'(ifc.wr_data_valid), 0);
        chk("b5 rst fifo_rd_en", int'(ifc.fifo_rd_en), 0);
        chk("b5 rst wr_data", int'(ifc.wr_data), 0);
        chk("b5 rst frame_done", int'(ifc.frame_done), 0);
        cyc();
        cyc();
        reset = 1'b1;

        // burst 6: after reset the address restarts at 0, data continues in FIFO order
        rdy_mode = 2;
        clr();
        push(BL, 1'b0);
        burst_done("b6", 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_burst_drain.md
FIFO_BURST_DRAIN -- requirements
Module: fifo_burst_drain

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256, words per burst (power of two, 2..512).
REQ-002 SHALL have parameter ADDR_W, default 22, width of the word address.
REQ-003 SHALL have parameter FRAME_WORDS, default 307200, words per frame (a multiple of BURST_LEN).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, permits starting new bursts.
REQ-007 SHALL have port frame_start, input, 1, single-cycle pulse that restarts the address at 0.
REQ-008 SHALL have port fifo_usedw, input, 10, FIFO fill level in words.
REQ-009 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-010 SHALL have port fifo_q, input, 16, show-ahead FIFO head word.
REQ-011 SHALL have port fifo_rd_en, output, 1, pops the FIFO head.
REQ-012 SHALL have port wr_req, output, 1, burst request to the memory writer.
REQ-013 SHALL have port wr_ack, input, 1, single-cycle grant of wr_req.
REQ-014 SHALL have port wr_addr, output, ADDR_W, burst start word address.
REQ-015 SHALL have port wr_data, output, 16, burst data word.
REQ-016 SHALL have port wr_data_valid, output, 1, wr_data is valid.
REQ-017 SHALL have port wr_data_ready, input, 1, sink accepts wr_data this cycle.
REQ-018 SHALL have port frame_done, output, 1, single-cycle pulse after the last burst of a frame.
REQ-019 SHALL have port underflow_err, output, 1, sticky flag for an empty FIFO during DATA.

Function
REQ-020 SHALL implement the states IDLE, REQ, DATA and DONE.
REQ-021 SHALL go from IDLE to REQ when en=1, fifo_usedw>=BURST_LEN and no stop condition (REQ-031) is active.
REQ-022 SHALL hold wr_req=1 and wr_addr stable in REQ, and go to DATA on the cycle after wr_ack=1; wr_ack outside REQ is ignored.
REQ-023 SHALL, in DATA, drive wr_data=fifo_q, wr_data_valid=~fifo_empty and fifo_rd_en=wr_data_valid&wr_data_ready (combinational, zero latency).
REQ-024 SHALL count one transfer per cycle in which fifo_rd_en=1; the BURST_LEN-th transfer moves DATA to DONE.
REQ-025 SHALL set underflow_err when fifo_empty=1 in DATA; DATA then stalls without popping and without counting.
REQ-026 SHALL, in DONE (exactly one cycle), advance the address by BURST_LEN and then return to IDLE.
REQ-027 SHALL let en=0 block new bursts only; a burst already in REQ or DATA completes.
REQ-028 SHALL, on frame_start in IDLE or DONE, load address 0 on the next edge, overriding the DONE increment.
REQ-029 SHALL, on frame_start in REQ or DATA, hold it pending and apply it at DONE.
REQ-030 SHALL clear a stop condition and underflow_err on frame_start.
REQ-031 SHALL pulse frame_done for one cycle when the DONE increment reaches FRAME_WORDS; the address then follows the Configuration section.

Reset
REQ-032 SHALL, on reset=0, asynchronously force state IDLE and address 0.
REQ-033 SHALL, on reset=0, clear the transfer counter, stop flag, pending frame_start and underflow_err.
REQ-034 SHALL, on reset=0, drive wr_req=0, wr_data_valid=0, fifo_rd_en=0, frame_done=0 and wr_data=0.
REQ-035 SHALL abort a burst on mid-burst reset with no completion and no address advance.

Configuration
REQ-036 SHALL support the macro FRAME_WRAP_EN.
REQ-037 SHALL, with FRAME_WRAP_EN defined, wrap the address to 0 at FRAME_WORDS and keep bursting continuously.
REQ-038 SHALL, without FRAME_WRAP_EN, hold the address at FRAME_WORDS at frame end and set the stop condition, so no new burst starts until frame_start.

Verification
REQ-039 SHALL cover: usedw=256, ack after 3 cycles, ready=1 constant -> wr_req high 4 cycles, 256 pops of the sequence 0..255, wr_addr 0 then 256.
REQ-040 SHALL cover: wr_data_ready toggling 1/0 -> 256 pops over 512 cycles, data order preserved, no duplicates.
REQ-041 SHALL cover: fifo_empty asserted for 5 cycles mid-burst -> fifo_rd_en=0 for those cycles, underflow_err=1 until frame_start, burst still completes.
REQ-042 SHALL cover: FRAME_WORDS=512, three bursts -> frame_done after the 2nd burst; with FRAME_WRAP_EN the 3rd burst uses addr 0; without it, no 3rd burst until frame_start.
REQ-043 SHALL cover: frame_start during DATA of the burst at addr 256 -> burst finishes, next wr_addr=0.
REQ-044 SHALL cover: reset=0 in the middle of DATA -> all outputs 0 immediately; after release, the next burst uses addr 0.
